// File: rtl/pos_vec_builder.sv
// Position-stream to bitmap builder: sets addressed bits per accepted beat,
// hands the finished vector, popcount and flags out on a valid/ready port.
module pos_vec_builder #(
   parameter int DW    = 8,
   parameter int POS_W = (DW == 1) ? 1 : $clog2(DW)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pos_valid_i,
   input  logic [POS_W-1:0] pos_i,
   input  logic             pos_last_i,
   output logic             pos_ready_o,
   output logic             vec_valid_o,
   output logic [DW-1:0]    vec_o,
   output logic [POS_W:0]   vec_cnt_o,
   output logic             vec_dup_o,
   output logic             vec_err_o,
   input  logic             vec_ready_i
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    acc, acc_nxt;
   logic [POS_W:0]   cnt, cnt_nxt;
   logic             dup, dup_nxt;
   logic             err, err_nxt;
   logic [DW-1:0]    onehot;
   logic             in_rng;
   logic             hit;
   logic             accept;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         dup   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         dup   <= dup_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      dup_nxt     = dup;
      err_nxt     = err;
      pos_ready_o = (state == ACCUM) && !rst_i;
      vec_valid_o = (state == HOLD);
      accept      = pos_valid_i && pos_ready_o;

      // Out-of-range positions decode to an all-zero mask.
      onehot = '0;
      for (int i = 0; i < DW; i++) begin
         onehot[i] = (int'(pos_i) == i);
      end
      in_rng = |onehot;
      hit    = |(acc & onehot);

      unique case (state)
         ACCUM: begin
            if (accept) begin
               if (!in_rng) begin
                  err_nxt = 1'b1;
               end else if (hit) begin
                  dup_nxt = 1'b1;
               end else begin
                  acc_nxt = acc | onehot;
                  cnt_nxt = cnt + (POS_W+1)'(1);
               end
               if (pos_last_i) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (vec_ready_i) begin
               state_nxt = ACCUM;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               dup_nxt   = 1'b0;
               err_nxt   = 1'b0;
            end
         end
      endcase
   end

   assign vec_o     = acc;
   assign vec_cnt_o = cnt;
   assign vec_dup_o = dup;
   assign vec_err_o = err;

endmodule
